mem_arbiter: RTL and testbench

- Shares the single-ported RAM between instruction fetch (read-only) and the memory stage (read/write) of the 5-stage pipeline.
- Arbitrates requests, holds the grant for the full variable-latency RAM access, and drives per-requester wait signals that stall the pipeline.
- Data has priority, with a starvation guard for instruction fetch and a sticky timeout fault for a hung RAM.

---
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Purpose: shares one single-ported RAM between instruction fetch and the data stage; data wins, fetch has a starvation guard.
// Latency: grant one cycle after a request is seen in IDLE; wait drops in the grant cycle where ram_ready is high; one IDLE bubble between accesses.
// Backpressure: iwait/dwait stall the requesters until their access completes; a hung RAM drops into a sticky ERR state.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int TIMEOUT      = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ram_ready,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    output logic              iwait,
    output logic              dwait,
    output logic [DATA_W-1:0] iload,
    output logic [DATA_W-1:0] dload,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_D = 2'd1,
        GRANT_I = 2'd2,
        ERR     = 2'd3
    } state_t;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    state_t            state_q, state_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              op_q, op_d;      // 1 = write, only meaningful in GRANT_D

    logic dreq;
    logic force_i;

    assign dreq    = dREN | dWEN;
    // Fetch has been passed over too many times: it takes the next grant.
    assign force_i = iREN && (streak_q == STARVE_MAX);

    // Next-state: arbitration in IDLE, completion/timeout in grant states, ERR is terminal.
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        timer_d  = timer_q;
        err_d    = err_q;
        addr_d   = addr_q;
        data_d   = data_q;
        op_d     = op_q;
        case (state_q)
            IDLE: begin
                if (dreq && !force_i) begin
                    state_d = GRANT_D;
                    addr_d  = daddr;
                    data_d  = dstore;
                    op_d    = dWEN;
                    timer_d = '0;
                    if (!iREN) begin
                        streak_d = '0;
                    end else if (streak_q != STARVE_MAX) begin
                        streak_d = streak_q + SW'(1);
                    end
                end else if (iREN) begin
                    state_d  = GRANT_I;
                    addr_d   = iaddr;
                    data_d   = '0;
                    op_d     = 1'b0;
                    timer_d  = '0;
                    streak_d = '0;
                end
            end
            GRANT_D, GRANT_I: begin
                // Always back to IDLE on completion: the owner still holds its
                // request this cycle, so re-arbitrating now would issue it twice.
                if (ram_ready) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                    if (timer_q == TMO_LAST) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latch registers; reset drops the grant asynchronously.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            streak_q <= '0;
            timer_q  <= '0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            op_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            timer_q  <= timer_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            op_q     <= op_d;
        end
    end

    // RAM strobes, waits and read-data steering from the registered grant.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iload    = '0;
        dload    = '0;
        iwait    = iREN;
        dwait    = dreq;
        err      = err_q;
        case (state_q)
            GRANT_D: begin
                ramaddr  = addr_q;
                ramstore = data_q;
                ramWEN   = op_q;
                ramREN   = !op_q;
                if (ram_ready) begin
                    dwait = 1'b0;
                    // A flushed request gets no data back.
                    if (!op_q && dreq) begin
                        dload = ramload;
                    end
                end
            end
            GRANT_I: begin
                ramaddr = addr_q;
                ramREN  = 1'b1;
                if (ram_ready) begin
                    iwait = 1'b0;
                    if (iREN) begin
                        iload = ramload;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int TMO = 15;
    localparam int SL  = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN, ram_ready;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic        ramREN, ramWEN, iwait, dwait, err;
    logic [31:0] ramaddr, ramstore, iload, dload;

    int compared   = 0;
    int mismatched = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO), .STARVE_LIMIT(SL)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .ramload(ramload), .ram_ready(ram_ready),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload), .err(err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Leaves the bench at posedge+1 with reset released and all inputs idle.
    task automatic do_reset();
        nRST = 1'b0;
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    // ---------------- behavioural reference model ----------------
    // owner: 0 nobody, 1 data port, 2 fetch port, 3 faulted
    int          m_own, m_age, m_streak;
    logic [31:0] m_addr, m_data;
    logic        m_wr;

    task automatic model_reset();
        m_own = 0; m_age = 0; m_streak = 0;
        m_addr = '0; m_data = '0; m_wr = 1'b0;
    endtask

    task automatic model_check();
        logic done_i, done_d, dq;
        dq     = dREN | dWEN;
        done_i = (m_own == 2) && ram_ready;
        done_d = (m_own == 1) && ram_ready;
        chk1("rnd.ramREN", ramREN, (m_own == 2) || (m_own == 1 && !m_wr));
        chk1("rnd.ramWEN", ramWEN, (m_own == 1) && m_wr);
        chk("rnd.ramaddr", ramaddr, (m_own == 1 || m_own == 2) ? m_addr : 32'h0);
        chk("rnd.ramstore", ramstore, (m_own == 1) ? m_data : 32'h0);
        chk1("rnd.iwait", iwait, iREN && !done_i);
        chk1("rnd.dwait", dwait, dq && !done_d);
        chk("rnd.iload", iload, (done_i && iREN) ? ramload : 32'h0);
        chk("rnd.dload", dload, (done_d && !m_wr && dq) ? ramload : 32'h0);
        chk1("rnd.err", err, m_own == 3);
    endtask

    task automatic model_step();
        if (m_own == 0) begin
            if ((dREN | dWEN) && !(iREN && m_streak >= SL)) begin
                m_own = 1; m_age = 0; m_addr = daddr; m_data = dstore; m_wr = dWEN;
                m_streak = iREN ? ((m_streak + 1 > SL) ? SL : m_streak + 1) : 0;
            end else if (iREN) begin
                m_own = 2; m_age = 0; m_addr = iaddr; m_data = '0; m_wr = 1'b0;
                m_streak = 0;
            end
        end else if (m_own == 1 || m_own == 2) begin
            if (ram_ready) m_own = 0;
            else begin
                m_age++;
                if (m_age >= TMO) m_own = 3;
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        i, d, w, r;
        logic [31:0] ia, da, ds, rl;
        logic        eren, ewen;
        logic [31:0] eaddr, estore;
        logic        eiw, edw;
        logic [31:0] eil, edl;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int exp_g [6];
        int grants [$];
        int nact;
        int thr;

        // single fetch, then a write, then data/fetch collision with one bubble
        tbl[0]  = '{1,0,0,0, 32'h100, 0, 0, 0,                        0,0, 0, 0,                       1,0, 0, 0};
        tbl[1]  = '{1,0,0,0, 32'h100, 0, 0, 0,                        1,0, 32'h100, 0,                 1,0, 0, 0};
        tbl[2]  = '{1,0,0,0, 32'h100, 0, 0, 0,                        1,0, 32'h100, 0,                 1,0, 0, 0};
        tbl[3]  = '{1,0,0,1, 32'h100, 0, 0, 32'h2409000A,             1,0, 32'h100, 0,                 0,0, 32'h2409000A, 0};
        tbl[4]  = '{0,1,1,0, 0, 32'h40, 32'hDEADBEEF, 32'h1234,       0,0, 0, 0,                       0,1, 0, 0};
        tbl[5]  = '{0,1,1,1, 0, 32'h40, 32'hDEADBEEF, 32'h1234,       0,1, 32'h40, 32'hDEADBEEF,       0,0, 0, 0};
        tbl[6]  = '{1,1,0,0, 32'h200, 32'h80, 32'h11111111, 0,        0,0, 0, 0,                       1,1, 0, 0};
        tbl[7]  = '{1,1,0,1, 32'h200, 32'h80, 32'h11111111, 32'hCAFE0001, 1,0, 32'h80, 32'h11111111,   1,0, 0, 32'hCAFE0001};
        tbl[8]  = '{1,0,0,0, 32'h200, 0, 0, 0,                        0,0, 0, 0,                       1,0, 0, 0};
        tbl[9]  = '{1,0,0,1, 32'h200, 0, 0, 32'h55,                   1,0, 32'h200, 0,                 0,0, 32'h55, 0};
        tbl[10] = '{0,0,0,0, 0, 0, 0, 0,                              0,0, 0, 0,                       0,0, 0, 0};

        // reset state, with requests and RAM activity visible on the inputs
        nRST = 1'b0;
        iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1; ram_ready = 1'b1;
        iaddr = 32'h10; daddr = 32'h20; dstore = 32'h30; ramload = 32'h40;
        #3;
        chk1("rst.ramREN", ramREN, 1'b0);
        chk1("rst.ramWEN", ramWEN, 1'b0);
        chk("rst.ramaddr", ramaddr, 32'h0);
        chk("rst.ramstore", ramstore, 32'h0);
        chk("rst.iload", iload, 32'h0);
        chk("rst.dload", dload, 32'h0);
        chk1("rst.err", err, 1'b0);
        chk1("rst.iwait", iwait, 1'b1);
        chk1("rst.dwait", dwait, 1'b1);

        do_reset();
        for (int k = 0; k < 11; k++) begin
            iREN = tbl[k].i; dREN = tbl[k].d; dWEN = tbl[k].w; ram_ready = tbl[k].r;
            iaddr = tbl[k].ia; daddr = tbl[k].da; dstore = tbl[k].ds; ramload = tbl[k].rl;
            #4;
            chk1($sformatf("v%0d.ramREN", k), ramREN, tbl[k].eren);
            chk1($sformatf("v%0d.ramWEN", k), ramWEN, tbl[k].ewen);
            chk($sformatf("v%0d.ramaddr", k), ramaddr, tbl[k].eaddr);
            chk($sformatf("v%0d.ramstore", k), ramstore, tbl[k].estore);
            chk1($sformatf("v%0d.iwait", k), iwait, tbl[k].eiw);
            chk1($sformatf("v%0d.dwait", k), dwait, tbl[k].edw);
            chk($sformatf("v%0d.iload", k), iload, tbl[k].eil);
            chk($sformatf("v%0d.dload", k), dload, tbl[k].edl);
            chk1($sformatf("v%0d.err", k), err, 1'b0);
            @(posedge CLK); #1;
        end

        // starvation: fetch held while data keeps requesting
        do_reset();
        iREN = 1'b1; iaddr = 32'h300; dREN = 1'b1; daddr = 32'h400; ram_ready = 1'b1;
        exp_g = '{1, 1, 1, 1, 2, 1};
        for (int c = 0; c < 40 && grants.size() < 6; c++) begin
            #4;
            if (ramREN) begin
                if (ramaddr == 32'h300) begin
                    grants.push_back(2);
                    chk1("starve.dwait_during_fetch", dwait, 1'b1);
                    chk1("starve.iwait_during_fetch", iwait, 1'b0);
                end else begin
                    grants.push_back(1);
                end
            end
            @(posedge CLK); #1;
        end
        chk("starve.grant_count", grants.size(), 6);
        for (int k = 0; k < 6; k++)
            chk($sformatf("starve.g%0d", k), (k < grants.size()) ? grants[k] : 0, exp_g[k]);

        // timeout: RAM never answers
        do_reset();
        dREN = 1'b1; daddr = 32'h44; iREN = 1'b1; iaddr = 32'h10; ram_ready = 1'b0;
        nact = 0;
        for (int c = 0; c < 16; c++) begin
            #4;
            if (ramREN) nact++;
            @(posedge CLK); #1;
        end
        chk("tmo.grant_cycles", nact, TMO);
        #4;
        chk1("tmo.err", err, 1'b1);
        chk1("tmo.ramREN", ramREN, 1'b0);
        chk1("tmo.ramWEN", ramWEN, 1'b0);
        chk1("tmo.iwait", iwait, 1'b1);
        chk1("tmo.dwait", dwait, 1'b1);
        ram_ready = 1'b1;
        @(posedge CLK); #4;
        chk1("tmo.err_sticky", err, 1'b1);
        nRST = 1'b0;
        #1;
        chk1("tmo.err_cleared", err, 1'b0);
        @(posedge CLK); #1 nRST = 1'b1;
        #4;
        chk1("tmo.idle_ramREN", ramREN, 1'b0);
        @(posedge CLK); #4;
        chk1("tmo.regrant_ramREN", ramREN, 1'b1);
        @(posedge CLK); #1;

        // flush: data request dropped mid-grant
        do_reset();
        dREN = 1'b1; daddr = 32'h90; ram_ready = 1'b0;
        #4 chk1("flush.idle", ramREN, 1'b0);
        @(posedge CLK); #4 chk1("flush.g1", ramREN, 1'b1);
        @(posedge CLK); #1 dREN = 1'b0;
        #3;
        chk1("flush.g2_ramREN", ramREN, 1'b1);
        chk("flush.g2_ramaddr", ramaddr, 32'h90);
        chk1("flush.g2_dwait", dwait, 1'b0);
        @(posedge CLK); #1 ram_ready = 1'b1; ramload = 32'hBAD0BAD0;
        #3;
        chk1("flush.done_ramREN", ramREN, 1'b1);
        chk("flush.done_dload", dload, 32'h0);
        @(posedge CLK); #1 ram_ready = 1'b0;
        #3 chk1("flush.back_idle", ramREN, 1'b0);

        // asynchronous reset in the middle of a fetch
        do_reset();
        iREN = 1'b1; iaddr = 32'h500;
        @(posedge CLK); #3;
        chk1("arst.granted", ramREN, 1'b1);
        nRST = 1'b0;
        #1;
        chk1("arst.ramREN", ramREN, 1'b0);
        chk("arst.ramaddr", ramaddr, 32'h0);

        // randomized traffic against the reference model
        do_reset();
        model_reset();
        thr = 60;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0 && cyc % 250 == 0) begin
                do_reset();
                model_reset();
                thr = ((cyc / 250) % 4 == 3) ? 5 : 60;
            end
            iREN      = 1'($urandom_range(0, 1));
            dREN      = 1'($urandom_range(0, 1));
            dWEN      = ($urandom_range(0, 3) == 0);
            ram_ready = ($urandom_range(0, 99) < thr);
            iaddr     = $urandom;
            daddr     = $urandom;
            dstore    = $urandom;
            ramload   = $urandom;
            #4;
            model_check();
            @(posedge CLK);
            model_step();
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
